alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Command-driven sequencer for the team's 16-bit 4-op ALU (tModule: add/sub/and/or + addCarry/subCarry).
//  Accepts {op, A, B, chain} commands over valid/ready, holds ALU operands registered for SETTLE cycles,
//  captures result + overflow flag and returns them over valid/ready. Chain mode feeds previous result back as A.
//  Sits between the board-level input logic (switches/buttons/UART) and the combinational ALU instance.
// PARAMETERS
//  NB_size  16  ALU data width (signed two's complement)
//  NB_OP    2   op select width (00 add, 01 sub, 10 and, 11 or)
//  SETTLE   1   cycles operands are held on ALU before capture; legal >= 1
//  NB_CNT   8   width of completed-operation counter
// PORTS
//  i_clk            in   1        clock, all logic on rising edge
//  i_reset          in   1        synchronous reset, active-high
//  i_cmd_valid      in   1        command present
//  o_cmd_ready      out  1        sequencer can accept command
//  i_cmd_op         in   NB_OP    operation select
//  i_cmd_chain      in   1        1: use accumulator as A, ignore i_cmd_dataA
//  i_cmd_dataA      in   NB_size  operand A (signed)
//  i_cmd_dataB      in   NB_size  operand B (signed)
//  o_alu_sel        out  NB_OP    to ALU i_sel (registered)
//  o_alu_dataA      out  NB_size  to ALU i_dataA (registered)
//  o_alu_dataB      out  NB_size  to ALU i_dataB (registered)
//  i_alu_dataC      in   NB_size  from ALU o_dataC
//  i_alu_addCarry   in   1        from ALU addCarry
//  i_alu_subCarry   in   1        from ALU subCarry
//  o_res_valid      out  1        result present
//  i_res_ready      in   1        consumer accepts result
//  o_res_data       out  NB_size  captured result
//  o_res_flag       out  1        overflow flag for captured op
//  o_busy           out  1        state != IDLE
//  o_op_count       out  NB_CNT   results delivered, wraps modulo 2^NB_CNT
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 except o_cmd_ready=1; accumulator=0; settle counter=0.
//  - FSM IDLE -> EXEC -> DONE -> IDLE. o_cmd_ready=1 only in IDLE; o_res_valid=1 only in DONE.
//  - IDLE: on edge with i_cmd_valid&o_cmd_ready: load o_alu_sel=i_cmd_op, o_alu_dataB=i_cmd_dataB,
//    o_alu_dataA = i_cmd_chain ? accumulator : i_cmd_dataA; settle counter=SETTLE-1; go EXEC.
//  - EXEC: o_alu_* held constant. Counter==0 at edge: capture o_res_data=i_alu_dataC,
//    accumulator=i_alu_dataC, o_res_flag = op00: addCarry, op01: subCarry, op1x: 0; go DONE.
//    Otherwise decrement counter.
//  - Latency: command accepted at edge t -> o_res_valid high after edge t+SETTLE.
//  - DONE: o_res_data/o_res_flag stable while o_res_valid=1 and !i_res_ready (unbounded backpressure).
//    On edge with i_res_ready: o_op_count+=1 (wrap), go IDLE; o_res_valid drops, o_cmd_ready rises
//    same edge. No bypass: max one command per SETTLE+2 cycles.
//  - o_alu_* keep last operands in IDLE/DONE (no glitching to ALU); o_res_data holds last result in IDLE.
//  - i_cmd_* ignored outside IDLE; commands never dropped (valid must stay high until ready).
//  - Chain with accumulator=0 after reset is legal (A=0).
//  - Arithmetic wraps at NB_size bits; sequencer does no arithmetic besides counters.
//  - i_reset in any state, incl. mid-EXEC or DONE: aborts op, result lost, all regs to reset values next edge.
// TESTING (bench instantiates tModule NB_size=16 driven by o_alu_*, SETTLE=1 and SETTLE=3)
//  1 add: op00 A=10000 B=5000 -> o_res_valid after edge t+SETTLE, data=15000, flag=0, count=1.
//  2 overflow: op00 A=30000 B=30000 -> data=-5536 flag=1; op01 A=-30000 B=30000 -> data=5536 flag=1.
//  3 logic + chain: op10 A=16'hAAAA B=16'hCCCC -> 16'h8888 flag=0; then chain op11 B=16'h0003 -> 16'h888B.
//  4 backpressure: hold i_res_ready=0 for 5 cycles -> valid/data/flag stable, o_cmd_ready=0, new cmd not taken.
//  5 reset mid-EXEC (SETTLE=3, reset 1 cycle after accept) -> no result, o_cmd_ready=1, count=0, chain gives A=0.
//  6 wrap: 256 back-to-back add commands with i_res_ready=1 -> o_op_count returns to 0, spacing SETTLE+2 cycles.

Source files
------------

// File: rtl/alu_cmd_sequencer_if.sv
// rtl/alu_cmd_sequencer_if.sv - command, ALU and result bundle for alu_cmd_sequencer
// slave = sequencer side, master = driver/ALU/consumer side.
interface alu_cmd_sequencer_if #(
  parameter int NB_size = 16,
  parameter int NB_OP   = 2,
  parameter int NB_CNT  = 8
) ();
  logic               i_cmd_valid;
  logic               o_cmd_ready;
  logic [NB_OP-1:0]   i_cmd_op;
  logic               i_cmd_chain;
  logic [NB_size-1:0] i_cmd_dataA;
  logic [NB_size-1:0] i_cmd_dataB;

  logic [NB_OP-1:0]   o_alu_sel;
  logic [NB_size-1:0] o_alu_dataA;
  logic [NB_size-1:0] o_alu_dataB;
  logic [NB_size-1:0] i_alu_dataC;
  logic               i_alu_addCarry;
  logic               i_alu_subCarry;

  logic               o_res_valid;
  logic               i_res_ready;
  logic [NB_size-1:0] o_res_data;
  logic               o_res_flag;

  logic               o_busy;
  logic [NB_CNT-1:0]  o_op_count;

  modport slave (
    input  i_cmd_valid, i_cmd_op, i_cmd_chain, i_cmd_dataA, i_cmd_dataB,
    input  i_alu_dataC, i_alu_addCarry, i_alu_subCarry, i_res_ready,
    output o_cmd_ready, o_alu_sel, o_alu_dataA, o_alu_dataB,
    output o_res_valid, o_res_data, o_res_flag, o_busy, o_op_count
  );

  modport master (
    output i_cmd_valid, i_cmd_op, i_cmd_chain, i_cmd_dataA, i_cmd_dataB,
    output i_alu_dataC, i_alu_addCarry, i_alu_subCarry, i_res_ready,
    input  o_cmd_ready, o_alu_sel, o_alu_dataA, o_alu_dataB,
    input  o_res_valid, o_res_data, o_res_flag, o_busy, o_op_count
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command sequencer holding operands on a combinational ALU
// IDLE accepts a command, EXEC holds operands SETTLE cycles, DONE presents the result.
module alu_cmd_sequencer #(
  parameter int NB_size = 16,
  parameter int NB_OP   = 2,
  parameter int SETTLE  = 1,
  parameter int NB_CNT  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  alu_cmd_sequencer_if.slave   io
);
  localparam int NB_SET = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [NB_SET-1:0]   r_settle;
  logic [NB_size-1:0]  r_acc;
  logic                w_take;
  logic                w_flag;

  assign w_take = io.i_cmd_valid & io.o_cmd_ready;

  // Overflow source follows the op latched on the ALU, not the live command.
  always_comb begin
    w_flag = 1'b0;
    if (io.o_alu_sel == NB_OP'(0))
      w_flag = io.i_alu_addCarry;
    else if (io.o_alu_sel == NB_OP'(1))
      w_flag = io.i_alu_subCarry;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= IDLE;
      r_settle       <= '0;
      r_acc          <= '0;
      io.o_cmd_ready <= 1'b1;
      io.o_alu_sel   <= '0;
      io.o_alu_dataA <= '0;
      io.o_alu_dataB <= '0;
      io.o_res_valid <= 1'b0;
      io.o_res_data  <= '0;
      io.o_res_flag  <= 1'b0;
      io.o_busy      <= 1'b0;
      io.o_op_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_take) begin
            io.o_alu_sel   <= io.i_cmd_op;
            io.o_alu_dataB <= io.i_cmd_dataB;
            io.o_alu_dataA <= io.i_cmd_chain ? r_acc : io.i_cmd_dataA;
            r_settle       <= NB_SET'(SETTLE - 1);
            io.o_cmd_ready <= 1'b0;
            io.o_busy      <= 1'b1;
            r_state        <= EXEC;
          end
        end
        EXEC: begin
          if (r_settle == '0) begin
            io.o_res_data  <= io.i_alu_dataC;
            r_acc          <= io.i_alu_dataC;
            io.o_res_flag  <= w_flag;
            io.o_res_valid <= 1'b1;
            r_state        <= DONE;
          end else begin
            r_settle <= r_settle - 1'b1;
          end
        end
        DONE: begin
          if (io.i_res_ready) begin
            io.o_op_count  <= io.o_op_count + 1'b1;
            io.o_res_valid <= 1'b0;
            io.o_cmd_ready <= 1'b1;
            io.o_busy      <= 1'b0;
            r_state        <= IDLE;
          end
        end
        default: begin
          r_state        <= IDLE;
          io.o_cmd_ready <= 1'b1;
          io.o_res_valid <= 1'b0;
          io.o_busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - randomized self-checking bench for alu_cmd_sequencer
// Two instances (SETTLE=1 and SETTLE=3) each driving a behavioural 16-bit ALU.
module tb_alu_cmd_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_s1 = 1'b1;
  logic rst_s3 = 1'b1;

  alu_cmd_sequencer_if if_s1 ();
  alu_cmd_sequencer_if if_s3 ();

  alu_cmd_sequencer #(.NB_size(16), .NB_OP(2), .SETTLE(1), .NB_CNT(8)) u_dut_s1 (
    .i_clk(clk), .i_reset(rst_s1), .io(if_s1.slave));
  alu_cmd_sequencer #(.NB_size(16), .NB_OP(2), .SETTLE(3), .NB_CNT(8)) u_dut_s3 (
    .i_clk(clk), .i_reset(rst_s3), .io(if_s3.slave));

  // Stand-in for the team ALU: {subCarry, addCarry, dataC}
  function automatic logic [17:0] alu_fn(input logic [1:0] sel, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [16:0] d;
    logic [15:0] c;
    s = {a[15], a} + {b[15], b};
    d = {a[15], a} - {b[15], b};
    case (sel)
      2'd0:    c = s[15:0];
      2'd1:    c = d[15:0];
      2'd2:    c = a & b;
      default: c = a | b;
    endcase
    return {d[16] ^ d[15], s[16] ^ s[15], c};
  endfunction

  assign {if_s1.i_alu_subCarry, if_s1.i_alu_addCarry, if_s1.i_alu_dataC} =
    alu_fn(if_s1.o_alu_sel, if_s1.o_alu_dataA, if_s1.o_alu_dataB);
  assign {if_s3.i_alu_subCarry, if_s3.i_alu_addCarry, if_s3.i_alu_dataC} =
    alu_fn(if_s3.o_alu_sel, if_s3.o_alu_dataA, if_s3.o_alu_dataB);

  virtual alu_cmd_sequencer_if vif;
  int          settle;
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] acc_m;
  int          cnt_m;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s (SETTLE=%0d): got %0d expected %0d", tag, settle, obs, exp);
    end
  endtask

  task automatic set_rst(input logic v);
    if (settle == 1) rst_s1 = v;
    else             rst_s3 = v;
  endtask

  // Reference: signed integer arithmetic with range test for overflow
  task automatic model(input int op, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] r, output logic f);
    int sa, sb, s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    f  = 1'b0;
    case (op)
      0:       begin s = sa + sb; f = (s > 32767) || (s < -32768); end
      1:       begin s = sa - sb; f = (s > 32767) || (s < -32768); end
      2:       s = int'(a & b);
      default: s = int'(a | b);
    endcase
    r = s[15:0];
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_cmd_ready"}, vif.o_cmd_ready, 1);
    check({pfx, "_res_valid"}, vif.o_res_valid, 0);
    check({pfx, "_busy"},      vif.o_busy, 0);
    check({pfx, "_op_count"},  vif.o_op_count, 0);
    check({pfx, "_res_data"},  vif.o_res_data, 0);
    check({pfx, "_res_flag"},  vif.o_res_flag, 0);
    check({pfx, "_alu_dataA"}, vif.o_alu_dataA, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_rst(1'b1);
    vif.i_cmd_valid = 1'b0;
    vif.i_res_ready = 1'b0;
    @(negedge clk);
    check_reset_state("reset");
    set_rst(1'b0);
    acc_m = '0;
    cnt_m = 0;
  endtask

  task automatic run_cmd(input int op, input bit chain, input logic [15:0] a,
                         input logic [15:0] b, input int hold);
    logic [15:0] ea, er;
    logic        ef;
    int          lat;
    @(negedge clk);
    check("cmd_ready_idle", vif.o_cmd_ready, 1);
    vif.i_cmd_valid = 1'b1;
    vif.i_cmd_op    = op[1:0];
    vif.i_cmd_chain = chain;
    vif.i_cmd_dataA = a;
    vif.i_cmd_dataB = b;
    ea = chain ? acc_m : a;
    model(op, ea, b, er, ef);
    @(negedge clk);
    vif.i_cmd_valid = 1'b0;
    vif.i_cmd_dataA = 16'($urandom);
    vif.i_cmd_dataB = 16'($urandom);
    check("alu_sel", vif.o_alu_sel, op);
    check("alu_dataA", vif.o_alu_dataA, ea);
    check("alu_dataB", vif.o_alu_dataB, b);
    check("busy_exec", vif.o_busy, 1);
    lat = 1;
    while (!vif.o_res_valid && lat <= 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, settle + 1);
    check("res_data", vif.o_res_data, er);
    check("res_flag", vif.o_res_flag, ef);
    check("cmd_ready_done", vif.o_cmd_ready, 0);
    for (int i = 0; i < hold; i++) begin
      vif.i_cmd_valid = 1'b1;
      vif.i_cmd_op    = 2'($urandom);
      vif.i_cmd_dataA = 16'($urandom);
      vif.i_cmd_chain = 1'b0;
      @(negedge clk);
      check("hold_valid", vif.o_res_valid, 1);
      check("hold_data", vif.o_res_data, er);
      check("hold_flag", vif.o_res_flag, ef);
      check("hold_cmd_ready", vif.o_cmd_ready, 0);
    end
    vif.i_cmd_valid = 1'b0;
    vif.i_res_ready = 1'b1;
    @(negedge clk);
    vif.i_res_ready = 1'b0;
    acc_m = er;
    cnt_m = (cnt_m + 1) % 256;
    check("post_res_valid", vif.o_res_valid, 0);
    check("post_cmd_ready", vif.o_cmd_ready, 1);
    check("post_busy", vif.o_busy, 0);
    check("op_count", vif.o_op_count, cnt_m);
    check("post_res_data", vif.o_res_data, er);
    check("post_alu_dataA", vif.o_alu_dataA, ea);
  endtask

  // Accept a command, then reset `extra` cycles later (0 = during EXEC).
  task automatic abort_cmd(input int extra);
    @(negedge clk);
    vif.i_cmd_valid = 1'b1;
    vif.i_cmd_op    = 2'd0;
    vif.i_cmd_chain = 1'b0;
    vif.i_cmd_dataA = 16'($urandom_range(1, 32767));
    vif.i_cmd_dataB = 16'($urandom_range(1, 32767));
    @(negedge clk);
    vif.i_cmd_valid = 1'b0;
    vif.i_res_ready = 1'b0;
    repeat (extra) @(negedge clk);
    set_rst(1'b1);
    @(negedge clk);
    check_reset_state("abort");
    set_rst(1'b0);
    acc_m = '0;
    cnt_m = 0;
    repeat (settle + 2) begin
      @(negedge clk);
      check("abort_no_result", vif.o_res_valid, 0);
    end
  endtask

  task automatic wrap_test();
    logic [15:0] a, b, er;
    logic        ef;
    int          done, last, cyc;
    do_reset();
    a = 16'($urandom);
    b = 16'($urandom);
    model(0, a, b, er, ef);
    @(negedge clk);
    vif.i_cmd_valid = 1'b1;
    vif.i_cmd_op    = 2'd0;
    vif.i_cmd_chain = 1'b0;
    vif.i_cmd_dataA = a;
    vif.i_cmd_dataB = b;
    vif.i_res_ready = 1'b1;
    done = 0;
    last = -1;
    cyc  = 0;
    while (done < 256 && cyc < 256 * (settle + 2) + 64) begin
      @(negedge clk);
      cyc++;
      if (vif.o_res_valid) begin
        done++;
        if (done == 256) vif.i_cmd_valid = 1'b0;
        if (last >= 0) check("wrap_spacing", cyc - last, settle + 2);
        last = cyc;
        check("wrap_data", vif.o_res_data, er);
        check("wrap_flag", vif.o_res_flag, ef);
      end
    end
    check("wrap_done", done, 256);
    vif.i_cmd_valid = 1'b0;
    @(negedge clk);
    vif.i_res_ready = 1'b0;
    check("wrap_count", vif.o_op_count, 0);
    check("wrap_cmd_ready", vif.o_cmd_ready, 1);
    acc_m = er;
    cnt_m = 0;
  endtask

  initial begin
    if_s1.i_cmd_valid = 1'b0; if_s1.i_res_ready = 1'b0; if_s1.i_cmd_op = '0;
    if_s1.i_cmd_chain = 1'b0; if_s1.i_cmd_dataA = '0;   if_s1.i_cmd_dataB = '0;
    if_s3.i_cmd_valid = 1'b0; if_s3.i_res_ready = 1'b0; if_s3.i_cmd_op = '0;
    if_s3.i_cmd_chain = 1'b0; if_s3.i_cmd_dataA = '0;   if_s3.i_cmd_dataB = '0;
    for (int s = 0; s < 2; s++) begin
      if (s == 0) begin vif = if_s1; settle = 1; end
      else        begin vif = if_s3; settle = 3; end
      do_reset();
      run_cmd(0, 1'b0, 16'd10000, 16'd5000, 0);
      check("add_15000", vif.o_res_data, 16'd15000);
      check("add_count1", vif.o_op_count, 1);
      run_cmd(0, 1'b0, 16'h7530, 16'h7530, 0);
      check("ovf_add_data", vif.o_res_data, 16'hEA60);
      check("ovf_add_flag", vif.o_res_flag, 1);
      run_cmd(1, 1'b0, 16'h8AD0, 16'h7530, 0);
      check("ovf_sub_data", vif.o_res_data, 16'h15A0);
      check("ovf_sub_flag", vif.o_res_flag, 1);
      run_cmd(2, 1'b0, 16'hAAAA, 16'hCCCC, 0);
      check("and_data", vif.o_res_data, 16'h8888);
      run_cmd(3, 1'b1, 16'hFFFF, 16'h0003, 0);
      check("chain_or_data", vif.o_res_data, 16'h888B);
      run_cmd(0, 1'b0, 16'($urandom), 16'($urandom), 5);
      abort_cmd(0);
      run_cmd(3, 1'b1, 16'h5555, 16'h1234, 0);
      check("chain_after_reset", vif.o_res_data, 16'h1234);
      abort_cmd(settle);
      for (int i = 0; i < 40; i++)
        run_cmd(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
      wrap_test();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
